uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one byte-level UART transmitter among `N_REQ` independent byte-stream requesters. It frames each requester's packet with a one-byte ID header, then streams the payload bytes. Pacing is by a fixed frame-time counter: it issues one `tx_start` per byte, never faster than one per `FRAME_CYCLES`. It sits between the producer blocks (NN result/status sources) and the UART transmitter.

---
 rtl/uart_tx_sched.sv | 127 ++++++++++++
 tb/tb_uart_tx_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin share of one byte UART transmitter.
// Each packet goes out as an ID header byte followed by its payload, one byte per frame time.
module uart_tx_sched #(
    parameter int N_REQ        = 4,
    parameter int FRAME_CYCLES = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    output logic               busy,
    output logic [3:0]         grant_id
);

    localparam int CW = $clog2(FRAME_CYCLES);
    localparam logic [CW-1:0] PACE_LOAD = CW'(FRAME_CYCLES - 2);
    localparam logic [3:0] LAST_RST = 4'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA, PACE} state_t;

    state_t        state, state_nx;
    logic [3:0]    grant, last_grant, pick;
    logic          any_valid;
    logic          last_flag;
    logic [CW-1:0] cnt;
    logic          gnt_valid, gnt_last;
    logic [7:0]    gnt_data;

    // Round-robin pick: lowest valid index above last_grant, else lowest overall
    always_comb begin
        any_valid = |req_valid;
        pick      = last_grant;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && i <= int'(last_grant)) pick = 4'(i);
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && i > int'(last_grant)) pick = 4'(i);
        end
    end

    // Mux the granted requester's byte stream
    always_comb begin
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        gnt_data  = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == 4'(i)) begin
                gnt_valid = req_valid[i];
                gnt_last  = req_last[i];
                gnt_data  = req_data[8*i +: 8];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (any_valid) state_nx = HDR;
            HDR:  state_nx = PACE;
            DATA: if (gnt_valid) state_nx = PACE;
            PACE: if (cnt == '0) state_nx = last_flag ? IDLE : DATA;
            default: state_nx = IDLE;
        endcase
    end

    // Grant, round-robin pointer, pace counter and last-byte flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant      <= 4'h0;
            last_grant <= LAST_RST;
            last_flag  <= 1'b0;
            cnt        <= '0;
        end else begin
            unique case (state)
                IDLE: if (any_valid) grant <= pick;
                HDR: begin
                    cnt       <= PACE_LOAD;
                    last_flag <= 1'b0;
                end
                DATA: if (gnt_valid) begin
                    cnt       <= PACE_LOAD;
                    last_flag <= gnt_last;
                end
                PACE: begin
                    if (cnt != '0)     cnt        <= cnt - CW'(1);
                    else if (last_flag) last_grant <= grant;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        tx_start  = 1'b0;
        tx_data   = 8'h00;
        req_ready = '0;
        busy      = (state != IDLE);
        grant_id  = grant;
        unique case (state)
            HDR: begin
                tx_start = 1'b1;
                tx_data  = {4'hA, grant};
            end
            DATA: if (gnt_valid) begin
                tx_start = 1'b1;
                tx_data  = gnt_data;
                for (int i = 0; i < N_REQ; i++) begin
                    if (grant == 4'(i)) req_ready[i] = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized and directed bench for uart_tx_sched.
// A timestamp-level reference model predicts every tx pulse, ready and grant.
module tb_uart_tx_sched;

    localparam int N  = 4;
    localparam int FC = 11;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic           tx_start, busy;
    logic [7:0]     tx_data;
    logic [3:0]     grant_id;

    uart_tx_sched #(.N_REQ(N), .FRAME_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef logic [8:0] bq_t[$];
    bq_t pq[N];
    int  gap_until[N];
    int  ready_cnt[N];
    int  n_chk = 0, n_pass = 0;
    int  cyc = 0;

    // model: phase 0 idle, 1 header due, 2 payload, 3 draining last frame
    int m_phase, m_owner, m_last, m_gid, m_hdr_at, m_next_at, m_idle_at;

    int         pulse_cyc[$];
    logic [7:0] pulse_dat[$];
    logic       prev_busy;
    int         busy_fall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    endtask

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_last = N - 1; m_gid = 0;
        m_idle_at = 0; m_hdr_at = 0; m_next_at = 0;
        for (int i = 0; i < N; i++) begin
            pq[i].delete();
            gap_until[i] = 0;
        end
        prev_busy = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            logic v;
            v = (pq[i].size() > 0) && (cyc >= gap_until[i]);
            req_valid[i]       = v;
            req_data[8*i +: 8] = v ? pq[i][0][7:0] : 8'h00;
            req_last[i]        = v ? pq[i][0][8] : 1'b0;
        end
    endtask

    task automatic push_pkt(input int r, input int len, input int base);
        for (int k = 0; k < len; k++)
            pq[r].push_back({(k == len - 1), 8'(base + k)});
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += pq[i].size();
        return s;
    endfunction

    task automatic step();
        logic         e_start, e_busy;
        logic [7:0]   e_data;
        logic [N-1:0] e_rdy, fire;
        int           e_gid, g;
        drive();
        @(negedge clk);
        e_start = 1'b0; e_data = 8'h00; e_rdy = '0;
        if (m_phase == 3 && cyc >= m_idle_at) begin
            m_phase = 0;
            m_last  = m_owner;
        end
        e_busy = (m_phase != 0);
        e_gid  = m_gid;
        if (m_phase == 0 && req_valid != '0) begin
            g = -1;
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (g < 0 && req_valid[i]) g = i;
            end
            m_owner = g; m_gid = g; m_phase = 1; m_hdr_at = cyc + 1;
        end else if (m_phase == 1 && cyc == m_hdr_at) begin
            e_start = 1'b1;
            e_data  = {4'hA, 4'(m_owner)};
            m_phase = 2;
            m_next_at = cyc + FC;
        end else if (m_phase == 2 && cyc >= m_next_at && req_valid[m_owner]) begin
            e_start = 1'b1;
            e_data  = pq[m_owner][0][7:0];
            e_rdy[m_owner] = 1'b1;
            m_next_at = cyc + FC;
            if (pq[m_owner][0][8]) begin
                m_phase = 3;
                m_idle_at = cyc + FC;
            end
        end
        chk("tx_start", 32'(tx_start), 32'(e_start));
        chk("tx_data", 32'(tx_data), 32'(e_data));
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("grant_id", 32'(grant_id), 32'(e_gid));
        if (tx_start) begin
            pulse_cyc.push_back(cyc);
            pulse_dat.push_back(tx_data);
        end
        if (prev_busy && !busy) busy_fall = cyc;
        prev_busy = busy;
        fire = req_valid & req_ready;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (fire[i]) begin
                void'(pq[i].pop_front());
                ready_cnt[i]++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((m_phase != 0 || pending() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_left", 32'(pending()), 32'd0);
    endtask

    task automatic clear_log();
        pulse_cyc.delete();
        pulse_dat.delete();
        for (int i = 0; i < N; i++) ready_cnt[i] = 0;
    endtask

    initial begin
        int hidx, lidx, gap_end, t_gap, n;
        int exp_hdr[$];
        logic [7:0] hdrs[$];

        rst = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0;
        model_reset();
        clear_log();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;

        // idle with no requests
        repeat (20) step();
        chk("idle_pulses", 32'(pulse_cyc.size()), 32'd0);

        // requester 2, three bytes
        clear_log();
        pq[2].push_back(9'h011);
        pq[2].push_back(9'h022);
        pq[2].push_back(9'h133);
        drain(200);
        chk("t2_npulse", 32'(pulse_dat.size()), 32'd4);
        if (pulse_dat.size() == 4) begin
            chk("t2_b0", 32'(pulse_dat[0]), 32'hA2);
            chk("t2_b1", 32'(pulse_dat[1]), 32'h11);
            chk("t2_b2", 32'(pulse_dat[2]), 32'h22);
            chk("t2_b3", 32'(pulse_dat[3]), 32'h33);
            for (int k = 1; k < 4; k++)
                chk("t2_gap", 32'(pulse_cyc[k] - pulse_cyc[k-1]), 32'(FC));
            chk("t2_busy_fall", 32'(busy_fall), 32'(pulse_cyc[3] + FC));
        end
        chk("t2_ready", 32'(ready_cnt[2]), 32'd3);

        // requesters 0,1,3 with 1-byte packets, round-robin from last grant 2
        clear_log();
        for (int r = 0; r < N; r++) begin
            if (r != 2) begin
                push_pkt(r, 1, 16 * r + 1);
                push_pkt(r, 1, 16 * r + 2);
            end
        end
        drain(400);
        exp_hdr = '{3, 0, 1, 3, 0, 1};
        hdrs.delete();
        foreach (pulse_dat[k]) if (k % 2 == 0) hdrs.push_back(pulse_dat[k]);
        chk("t3_nhdr", 32'(hdrs.size()), 32'd6);
        for (int k = 0; k < 6 && k < hdrs.size(); k++)
            chk("t3_order", 32'(hdrs[k]), 32'(8'hA0 | 8'(exp_hdr[k])));

        // requester 1 stalls 25 cycles while requester 0 waits
        clear_log();
        push_pkt(1, 4, 8'h41);
        n = 0;
        while (ready_cnt[1] < 1 && n < 60) begin
            step();
            n++;
        end
        chk("t4_first", 32'(ready_cnt[1]), 32'd1);
        push_pkt(0, 2, 8'h51);
        gap_until[1] = cyc + 25;
        gap_end = cyc + 25;
        t_gap = pulse_cyc.size();
        drain(400);
        chk("t4_resume", 32'(pulse_cyc[t_gap]), 32'(gap_end));
        hidx = -1; lidx = -1;
        foreach (pulse_dat[k]) begin
            if (pulse_dat[k] == 8'hA0 && hidx < 0) hidx = k;
            if (pulse_dat[k] == 8'h44) lidx = k;
        end
        chk("t4_order", 32'(hidx == lidx + 1 && lidx > 0), 32'd1);

        // reset five cycles into a payload pace interval
        clear_log();
        push_pkt(3, 4, 8'h61);
        n = 0;
        while (ready_cnt[3] < 1 && n < 60) begin
            step();
            n++;
        end
        repeat (5) step();
        chk("t5_busy_pre", 32'(busy), 32'd1);
        chk("t5_gid_pre", 32'(grant_id), 32'd3);
        rst = 1'b1;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_gid", 32'(grant_id), 32'd0);
        chk("t5_tx", 32'({tx_start, tx_data}), 32'd0);
        chk("t5_ready", 32'(req_ready), 32'd0);
        model_reset();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
        push_pkt(2, 2, 8'h71);
        push_pkt(0, 2, 8'h81);
        drain(200);
        chk("t5_first_hdr", 32'(pulse_dat[0]), 32'hA0);

        // randomized traffic with random stalls
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                int r;
                r = $urandom_range(0, N - 1);
                if (pq[r].size() == 0)
                    push_pkt(r, $urandom_range(1, 4), $urandom_range(0, 255));
            end
            if ($urandom_range(0, 29) == 0) begin
                int r;
                r = $urandom_range(0, N - 1);
                gap_until[r] = cyc + $urandom_range(1, 15);
            end
            step();
        end
        drain(2000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
